// File: rtl/keypad_debounce_scan_pkg.sv
// Shared keypad definitions: FSM states, idle row pattern and key-code width.
package keypad_pkg;

    localparam int unsigned KEY_W     = 4;
    localparam logic [3:0]  IDLE_ROWS = 4'b1111;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2
    } state_t;

endpackage

// File: rtl/keypad_debounce_scan_if.sv
// Keypad matrix lines plus the key/pressed/held result bundle.
interface keypad_debounce_scan_if;
    import keypad_pkg::*;

    logic [3:0]       swr;
    logic [3:0]       swc;
    logic [KEY_W-1:0] key;
    logic             pressed;
    logic             held;

    modport master (output swr, input swc, key, pressed, held);
    modport slave  (input swr, output swc, key, pressed, held);
endinterface

// File: rtl/keypad_debounce_scan_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_DIV clocks.
module scan_tick_gen #(
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic clk_50MHz,
    input  logic rst,
    output logic tick
);
    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/keypad_debounce_scan.sv
// 4x4 keypad column scanner with press/release debounce; one pressed strobe per key.
module keypad_debounce_scan
    import keypad_pkg::*;
#(
    parameter int unsigned CLK_DIV        = 50000,
    parameter int unsigned DEBOUNCE_TICKS = 20
) (
    input  logic                   clk_50MHz,
    input  logic                   rst,
    keypad_debounce_scan_if.slave  kp
);
    localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);

    logic             tick;
    logic [3:0]       sync1;
    logic [3:0]       rs;
    logic             hit;
    logic [1:0]       row_idx;
    logic [1:0]       col_idx;
    logic [1:0]       col_nxt;
    logic [3:0]       swc_nxt;
    logic [KEY_W-1:0] code;
    logic [KEY_W-1:0] cand;
    logic [DW-1:0]    dcnt;
    logic [DW-1:0]    dcnt_inc;
    logic             dcnt_done;
    state_t           state;
    logic [3:0]       swc_q;
    logic [KEY_W-1:0] key_q;
    logic             pressed_q;
    logic             held_q;

    scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .tick      (tick)
    );

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            sync1 <= IDLE_ROWS;
            rs    <= IDLE_ROWS;
        end else begin
            sync1 <= kp.swr;
            rs    <= sync1;
        end
    end

    // Scan from row 3 down so the lowest low row is written last and wins.
    always_comb begin
        row_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!rs[3 - i]) row_idx = 2'(3 - i);
        end
    end

    assign hit       = (rs != IDLE_ROWS);
    assign code      = {row_idx, col_idx};
    assign col_nxt   = col_idx + 2'd1;
    assign swc_nxt   = ~(4'b0001 << col_nxt);
    assign dcnt_inc  = dcnt + DW'(1);
    assign dcnt_done = (dcnt_inc == DW'(DEBOUNCE_TICKS));

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state     <= ST_SCAN;
            col_idx   <= '0;
            swc_q     <= 4'b1110;
            cand      <= '0;
            dcnt      <= '0;
            key_q     <= '0;
            pressed_q <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            pressed_q <= 1'b0;
            if (tick) begin
                unique case (state)
                    ST_SCAN: begin
                        if (hit) begin
                            cand  <= code;
                            dcnt  <= DW'(1);
                            state <= ST_DEBOUNCE;
                        end else begin
                            col_idx <= col_nxt;
                            swc_q   <= swc_nxt;
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (hit && (code == cand)) begin
                            if (dcnt_done) begin
                                key_q     <= cand;
                                pressed_q <= 1'b1;
                                held_q    <= 1'b1;
                                dcnt      <= '0;
                                state     <= ST_HOLD;
                            end else begin
                                dcnt <= dcnt_inc;
                            end
                        end else begin
                            col_idx <= col_nxt;
                            swc_q   <= swc_nxt;
                            state   <= ST_SCAN;
                        end
                    end
                    ST_HOLD: begin
                        // Any tick still seeing a row low restarts the release count.
                        if (hit) begin
                            dcnt <= '0;
                        end else if (dcnt_done) begin
                            held_q  <= 1'b0;
                            col_idx <= col_nxt;
                            swc_q   <= swc_nxt;
                            state   <= ST_SCAN;
                        end else begin
                            dcnt <= dcnt_inc;
                        end
                    end
                    default: state <= ST_SCAN;
                endcase
            end
        end
    end

    assign kp.swc     = swc_q;
    assign kp.key     = key_q;
    assign kp.pressed = pressed_q;
    assign kp.held    = held_q;
endmodule
